// File: rtl/seq_pair_streamer.sv
// Purpose : streams every (query letter i, database letter j) pair of two snapshotted sequences, row-major.
// Latency : first pair is valid the cycle after start is sampled; after that, one pair per cycle while out_ready is high.
// Backpr. : valid/ready handshake; while out_valid=1 and out_ready=0, every output holds.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            begin a sweep (honoured only in IDLE)
//   query_seq_in     query buffer, snapshotted on an accepted start
//   database_seq_in  database buffer, snapshotted on an accepted start
//   out_ready        downstream accepts the current pair
//   out_valid        current pair is valid
//   q_letter/d_letter  registered letters at (q_idx, d_idx)
//   q_idx/d_idx      row index i / column index j
//   last             current pair is (L-1, L-1)
//   busy             sweep in progress (STREAM or DONE)
//   done             one-cycle sweep-complete pulse
//   match            (SEQ_MATCH_FLAG_EN only) registered q_letter == d_letter flag
//
// Optional feature macro: SEQ_MATCH_FLAG_EN adds the match output.
module seq_pair_streamer #(
  parameter int NUM_REG      = 8,
  parameter int BITS_REG     = 8,
  parameter int LETTER_WIDTH = 2,
  localparam int L           = NUM_REG * BITS_REG / LETTER_WIDTH,
  localparam int IDX_W       = $clog2(L)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_REG-1:0][BITS_REG-1:0]   query_seq_in,
  input  logic [NUM_REG-1:0][BITS_REG-1:0]   database_seq_in,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [LETTER_WIDTH-1:0]            q_letter,
  output logic [LETTER_WIDTH-1:0]            d_letter,
  output logic [IDX_W-1:0]                   q_idx,
  output logic [IDX_W-1:0]                   d_idx,
  output logic                               last,
  output logic                               busy,
  output logic                               done
`ifdef SEQ_MATCH_FLAG_EN
  ,
  output logic                               match
`endif
);

  localparam int LPR   = BITS_REG / LETTER_WIDTH;  // letters per register
  localparam int REG_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(L - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_REG-1:0][BITS_REG-1:0] q_snap, d_snap;

  logic                    load, xfer, fin;
  logic                    j_wrap;
  logic [IDX_W-1:0]        i_nxt, j_nxt;
  logic [IDX_W-1:0]        q_sel_idx, d_sel_idx;
  logic [NUM_REG-1:0][BITS_REG-1:0] q_sel_seq, d_sel_seq;
  logic [LETTER_WIDTH-1:0] q_let_nxt, d_let_nxt;

  // Letter n lives in register n/LPR, slot n%LPR counted from the MSB end.
  function automatic logic [LETTER_WIDTH-1:0] letter_of(
    input logic [NUM_REG-1:0][BITS_REG-1:0] seq,
    input logic [IDX_W-1:0]                 n
  );
    logic [REG_W-1:0]    r;
    logic [BITS_REG-1:0] w;
    r = REG_W'(n / LPR);
    w = seq[r] << (LETTER_WIDTH * (n % LPR));
    return w[BITS_REG-1 -: LETTER_WIDTH];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          load      = 1'b1;
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          xfer = 1'b1;
          if (last) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Next indices: j runs fastest and wraps into an i increment.
  assign j_wrap = (d_idx == IDX_MAX);
  assign j_nxt  = j_wrap ? '0 : d_idx + 1'b1;
  assign i_nxt  = j_wrap ? q_idx + 1'b1 : q_idx;

  // On a load the snapshot is not written yet, so decode straight from the inputs.
  assign q_sel_seq = load ? query_seq_in    : q_snap;
  assign d_sel_seq = load ? database_seq_in : d_snap;
  assign q_sel_idx = load ? '0 : i_nxt;
  assign d_sel_idx = load ? '0 : j_nxt;
  assign q_let_nxt = letter_of(q_sel_seq, q_sel_idx);
  assign d_let_nxt = letter_of(d_sel_seq, d_sel_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_snap    <= '0;
      d_snap    <= '0;
      out_valid <= 1'b0;
      q_idx     <= '0;
      d_idx     <= '0;
      q_letter  <= '0;
      d_letter  <= '0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q_snap    <= query_seq_in;
        d_snap    <= database_seq_in;
        out_valid <= 1'b1;
        q_idx     <= '0;
        d_idx     <= '0;
        q_letter  <= q_let_nxt;
        d_letter  <= d_let_nxt;
        last      <= 1'b0;
      end else if (fin) begin
        out_valid <= 1'b0;
        q_idx     <= '0;
        d_idx     <= '0;
        q_letter  <= '0;
        d_letter  <= '0;
        last      <= 1'b0;
        done      <= 1'b1;
      end else if (xfer) begin
        q_idx     <= i_nxt;
        d_idx     <= j_nxt;
        q_letter  <= q_let_nxt;
        d_letter  <= d_let_nxt;
        last      <= (i_nxt == IDX_MAX) && (j_nxt == IDX_MAX);
      end
    end
  end

`ifdef SEQ_MATCH_FLAG_EN
  // Registered alongside the letters so it holds with them during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            match <= 1'b0;
    else if (load || (xfer && !fin)) match <= (q_let_nxt == d_let_nxt);
    else if (fin)          match <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seq_pair_streamer.sv
module tb_seq_pair_streamer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0][7:0]  qin, din;
  logic             out_ready;
  logic             out_valid;
  logic [1:0]       q_letter, d_letter;
  logic [4:0]       q_idx, d_idx;
  logic             last, busy, done;
`ifdef SEQ_MATCH_FLAG_EN
  logic             match;
`endif

  int checks = 0;
  int errors = 0;

  seq_pair_streamer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .query_seq_in    (qin),
    .database_seq_in (din),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .q_letter        (q_letter),
    .d_letter        (d_letter),
    .q_idx           (q_idx),
    .d_idx           (d_idx),
    .last            (last),
    .busy            (busy),
    .done            (done)
`ifdef SEQ_MATCH_FLAG_EN
    ,
    .match           (match)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference letter: register n/4 sits at bits [8r+7:8r]; slot n%4 counts from its MSB.
  function automatic logic [1:0] mletter(input logic [63:0] s, input int n);
    int pos;
    pos = 8 * (n / 4) + 6 - 2 * (n % 4);
    return 2'((s >> pos) & 64'h3);
  endfunction

  // One full sweep. Expected pair number cnt maps to (cnt/32, cnt%32).
  task automatic sweep(input int stall_at, input int stall_len, input bit rnd_rdy,
                       input int poke_at, input int abort_at, input bit basic);
    logic [63:0] qm, dm;
    logic [1:0]  eq, ed;
    int cnt, cyc, stalled, ei, ej;
    bit rdy, poked;
    @(negedge clk);
    start = 1'b1;
    qm = qin;
    dm = din;
    @(negedge clk);
    start   = 1'b0;
    cnt     = 0;
    cyc     = 0;
    stalled = 0;
    poked   = 1'b0;
    while (cnt < 1024 && cyc < 8000) begin
      ei = cnt / 32;
      ej = cnt % 32;
      eq = mletter(qm, ei);
      ed = mletter(dm, ej);
      chk("pair", {out_valid, q_idx, d_idx, q_letter, d_letter, last, done, busy},
          {1'b1, 5'(ei), 5'(ej), eq, ed, (cnt == 1023), 1'b0, 1'b1});
`ifdef SEQ_MATCH_FLAG_EN
      chk("match", match, (eq == ed));
`endif
      if (basic && cnt == 0) chk("basic_first", {q_letter, d_letter}, 4'b1010);
      if (basic && cnt == 1) chk("basic_second", d_letter, 2'b11);
      if (cnt == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {out_valid, busy, done, last, q_idx, d_idx, q_letter, d_letter}, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_hold", {out_valid, busy, done}, 3'b000);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_idle", {out_valid, busy, done, q_idx, d_idx}, 0);
        end
        return;
      end
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cnt == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      out_ready = rdy;
      if (cnt == poke_at && !poked) begin
        din   = {$urandom, $urandom};
        start = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rdy) cnt++;
    end
    chk("sweep_len", cnt, 1024);
    if (!rnd_rdy) chk("sweep_cycles", cyc, 1024 + stall_len);
    chk("done_pulse", {out_valid, done, busy, last}, 4'b0110);
    out_ready = 1'b1;
    @(negedge clk);
    chk("back_to_idle", {out_valid, done, busy}, 3'b000);
    @(negedge clk);
    chk("idle_quiet", {out_valid, done, busy}, 3'b000);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    qin       = '0;
    din       = '0;
    #3;
    chk("reset_state", {out_valid, busy, done, last, q_idx, d_idx, q_letter, d_letter}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready without valid must not start anything.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ready", {out_valid, busy, done, q_idx, d_idx}, 0);
    end

    // Basic sweep with known register 0 contents.
    qin    = '0;
    din    = '0;
    qin[0] = 8'b10011100;
    din[0] = 8'b10111011;
    sweep(-1, 0, 1'b0, -1, -1, 1'b1);

    // Backpressure for 5 cycles at pair (3,7).
    qin = {$urandom, $urandom};
    din = {$urandom, $urandom};
    sweep(3 * 32 + 7, 5, 1'b0, -1, -1, 1'b0);

    // Inputs change and start pulses mid-sweep: snapshot must be kept.
    qin = {$urandom, $urandom};
    din = {$urandom, $urandom};
    sweep(-1, 0, 1'b1, 50, -1, 1'b0);

    // Next sweep picks up the changed database contents.
    sweep(-1, 0, 1'b1, -1, -1, 1'b0);

    // Reset at pair (10,4), then a fresh sweep from (0,0).
    qin = {$urandom, $urandom};
    din = {$urandom, $urandom};
    sweep(-1, 0, 1'b0, -1, 10 * 32 + 4, 1'b0);
    qin = {$urandom, $urandom};
    din = {$urandom, $urandom};
    sweep(-1, 0, 1'b1, -1, -1, 1'b0);

    // Identical sequences: diagonal pairs all match.
    qin = {8{8'b10111011}};
    din = {8{8'b10111011}};
    sweep(-1, 0, 1'b0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pair_streamer.md
SEQ_PAIR_STREAMER -- requirements
Module: seq_pair_streamer

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REG, 8, registers per sequence
- BITS_REG, 8, bits per register
- LETTER_WIDTH, 2, bits per letter
- Derived: L = NUM_REG*BITS_REG/LETTER_WIDTH (32 letters per sequence).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin streaming a new cell sweep
- query_seq_in  in  [NUM_REG-1:0][BITS_REG-1:0]  loaded query buffer contents
- database_seq_in  in  [NUM_REG-1:0][BITS_REG-1:0]  loaded database buffer contents
- out_ready  in  1  downstream scoring array accepts the current pair
- out_valid  out  1  current pair is valid
- q_letter  out  LETTER_WIDTH  query letter i
- d_letter  out  LETTER_WIDTH  database letter j
- q_idx  out  $clog2(L)  row index i
- d_idx  out  $clog2(L)  column index j
- last  out  1  current pair is (L-1, L-1)
- busy  out  1  sweep in progress
- done  out  1  one-cycle sweep-complete pulse

Function
REQ-003 Letter n of a sequence SHALL be register n/LETTER_WIDTH... specifically register r = n/(BITS_REG/LETTER_WIDTH), slot k = n mod (BITS_REG/LETTER_WIDTH), MSB-first: bits [BITS_REG-1-2k : BITS_REG-2-2k].
REQ-004 FSM states SHALL be IDLE, STREAM and DONE.
REQ-005 IDLE with start=1 SHALL snapshot both input buffers into internal registers, enter STREAM, and at that edge drive out_valid=1, i=0, j=0.
- Latency: first pair is valid the cycle after start is sampled.
REQ-006 After the snapshot, query_seq_in and database_seq_in SHALL be ignored until the next accepted start.
REQ-007 Pairs SHALL be emitted in row-major order, with j incrementing fastest: (0,0), (0,1) … (0,L-1), (1,0) … (L-1,L-1); L*L pairs total.
REQ-008 A transfer SHALL occur on a clock edge where out_valid && out_ready; only then do the indices advance.
REQ-009 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-010 On transfer at j=L-1, the block SHALL wrap j to 0 and increment i.
REQ-011 last SHALL be asserted exactly when out_valid=1 and i=j=L-1.
REQ-012 A transfer with last=1 SHALL move the FSM to DONE, clear out_valid, and assert done for exactly one cycle.
REQ-013 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-014 busy SHALL be 1 in STREAM and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored in STREAM and DONE, with no restart and no snapshot.
- A start held across DONE is first accepted in IDLE.
REQ-016 q_letter and d_letter SHALL be registered outputs, decoded from the snapshot at the current indices.
REQ-017 out_ready=1 with out_valid=0 SHALL have no effect.
REQ-018 The maximum throughput SHALL be one pair per cycle with out_ready tied high.
- A full sweep then spans L*L cycles from the first valid to the last transfer.

Reset
REQ-019 rst_n=0 SHALL asynchronously force:
- FSM=IDLE
- out_valid=0, last=0, busy=0, done=0
- q_letter=0, d_letter=0, q_idx=0, d_idx=0
- snapshot registers=0
REQ-020 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
- After deassertion, the block SHALL wait in IDLE for a new start.

Configuration
REQ-021 Macro SEQ_MATCH_FLAG_EN, when defined, SHALL add output port match (1 bit).
- match is a registered output, equal to 1 when the emitted q_letter == d_letter and out_valid=1.
- match holds with the other outputs during stalls and resets to 0.
REQ-022 Without SEQ_MATCH_FLAG_EN, the match port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Basic sweep:
- Stimulus: query_seq_in[0]=8'b10011100, database_seq_in[0]=8'b10111011, start pulse, out_ready=1.
- Required: first pair q_letter=2'b10, d_letter=2'b10, (0,0).
- Required: second pair d_letter=2'b11, (0,1).
- Required: 1024 transfers, last on (31,31), then a single done pulse.
REQ-024 Row wrap:
- Stimulus: out_ready=1 through pair (0,31).
- Required: the next pair is (1,0), with q_letter=query letter 1 and d_letter=database letter 0.
REQ-025 Backpressure:
- Stimulus: drop out_ready for 5 cycles at pair (3,7).
- Required: all outputs hold (3,7) for those 5 cycles; streaming resumes with (3,8); total transfers remain 1024.
REQ-026 Snapshot and ignored start:
- Stimulus: change database_seq_in and pulse start during STREAM.
- Required: emitted letters are unchanged and no restart occurs.
- Stimulus: a start after done.
- Required: the new contents are used.
REQ-027 Reset mid-sweep:
- Stimulus: rst_n=0 at pair (10,4).
- Required: out_valid=0, busy=0, indices=0, and no done pulse.
- Stimulus: a new start after reset.
- Required: the sweep begins at (0,0).
REQ-028 Match flag (SEQ_MATCH_FLAG_EN defined):
- Stimulus: identical query and database, both 8'b10111011 in every register.
- Required: match=1 on every diagonal pair (i,i).
- Required: match=0 on pair (0,1), since letter 2'b10 differs from 2'b11.
